// File: rtl/nn_pkg.sv
// Shared types and helpers for the int8 two-layer MLP inference core.
package nn_pkg;

   localparam int ACC_W     = 32;
   localparam int PIX_W     = 8;
   localparam int WGT_W     = 8;
   localparam int CLS_W     = 4;
   localparam int N_IN_DEF  = 784;
   localparam int N_HID_DEF = 32;
   localparam int N_OUT_DEF = 10;
   localparam int SHIFT_DEF = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_L1_BIAS,
      S_L1_MAC,
      S_L1_ACT,
      S_L2_BIAS,
      S_L2_MAC,
      S_L2_CMP,
      S_DONE
   } state_t;

   // ReLU followed by arithmetic downscale and unsigned 8-bit saturation.
   function automatic logic [7:0] relu_requant(input logic signed [ACC_W-1:0] acc,
                                               input int shift);
      logic signed [ACC_W-1:0] q;
      q = acc >>> shift;
      if (acc <= 0) return 8'd0;
      if (q > 255) return 8'd255;
      return q[7:0];
   endfunction

endpackage

// File: rtl/nn_mlp_core_mac.sv
// Signed multiply-accumulate: unsigned 8-bit activation times signed 8-bit weight,
// accumulated modulo 2^ACC_W with a bias-load path.
module nn_mac
   import nn_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_bias,
   input  logic                    accumulate,
   input  logic signed [ACC_W-1:0] bias,
   input  logic [PIX_W-1:0]        a,
   input  logic signed [WGT_W-1:0] b,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [PIX_W+WGT_W:0] prod;

   assign prod = $signed({1'b0, a}) * b;

   always_ff @(posedge clk) begin
      if (!rst)
         acc <= '0;
      else if (load_bias)
         acc <= bias;
      else if (accumulate)
         acc <= acc + ACC_W'(prod);
   end

endmodule

// File: rtl/nn_mlp_core.sv
// Two-layer int8 MLP inference: dense MACs over external 1-cycle ROMs, ReLU requant, argmax.
// state     | meaning
// S_IDLE    | waiting for start; pixel writes accepted
// S_L1_BIAS | read b1[j]
// S_L1_MAC  | load bias, then one product per cycle over N_IN pixels
// S_L1_ACT  | requantise accumulator into h_mem[j]
// S_L2_BIAS | read b2[k]
// S_L2_MAC  | load bias, then one product per cycle over N_HID hidden units
// S_L2_CMP  | strict-greater argmax update (ties keep lowest k)
// S_DONE    | latch result; done pulses on the following cycle
module nn_mlp_core
   import nn_pkg::*;
#(
   parameter int  N_IN  = N_IN_DEF,
   parameter int  N_HID = N_HID_DEF,
   parameter int  N_OUT = N_OUT_DEF,
   parameter int  SHIFT = SHIFT_DEF,
   localparam int X_AW  = $clog2(N_IN),
   localparam int H_AW  = $clog2(N_HID),
   localparam int O_AW  = $clog2(N_OUT),
   localparam int W1_AW = $clog2(N_IN * N_HID),
   localparam int W2_AW = $clog2(N_HID * N_OUT)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   input  logic                    pix_we,
   input  logic [X_AW-1:0]         pix_addr,
   input  logic [PIX_W-1:0]        pix_data,
   output logic                    b1_en,
   output logic [H_AW-1:0]         b1_addr,
   input  logic signed [ACC_W-1:0] b1_dout,
   output logic                    w1_en,
   output logic [W1_AW-1:0]        w1_addr,
   input  logic [WGT_W-1:0]        w1_dout,
   output logic                    w2_en,
   output logic [W2_AW-1:0]        w2_addr,
   input  logic [WGT_W-1:0]        w2_dout,
   output logic                    b2_en,
   output logic [O_AW-1:0]         b2_addr,
   input  logic signed [ACC_W-1:0] b2_dout,
   output logic [CLS_W-1:0]        predicted,
   output logic signed [ACC_W-1:0] max_score
);

   localparam int CW = $clog2(N_IN + 1);

   state_t                  state, state_nxt;
   logic [CW-1:0]           idx;
   logic [H_AW-1:0]         j;
   logic [O_AW-1:0]         k;
   logic [PIX_W-1:0]        x_mem [N_IN];
   logic [7:0]              h_mem [N_HID];
   logic [PIX_W-1:0]        a_q;
   logic                    load_bias, acc_en;
   logic signed [ACC_W-1:0] mac_bias, acc, best_score;
   logic signed [WGT_W-1:0] mac_w;
   logic [CLS_W-1:0]        best_idx;
   logic                    last_j, last_k;

   assign last_j   = (int'(j) == N_HID - 1);
   assign last_k   = (int'(k) == N_OUT - 1);
   assign busy     = (state != S_IDLE);
   assign mac_bias = (state == S_L2_MAC) ? b2_dout : b1_dout;
   assign mac_w    = (state == S_L2_MAC) ? $signed(w2_dout) : $signed(w1_dout);

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      b1_en     = 1'b0;
      b1_addr   = '0;
      w1_en     = 1'b0;
      w1_addr   = '0;
      w2_en     = 1'b0;
      w2_addr   = '0;
      b2_en     = 1'b0;
      b2_addr   = '0;
      load_bias = 1'b0;
      acc_en    = 1'b0;
      case (state)
         S_IDLE: begin
            // done is high only in the cycle right after S_DONE; a start there is dropped
            if (start && !done) state_nxt = S_L1_BIAS;
         end
         S_L1_BIAS: begin
            b1_en     = 1'b1;
            b1_addr   = j;
            state_nxt = S_L1_MAC;
         end
         S_L1_MAC: begin
            load_bias = (idx == '0);
            acc_en    = (idx != '0);
            if (int'(idx) < N_IN) begin
               w1_en   = 1'b1;
               w1_addr = W1_AW'(j) * W1_AW'(N_IN) + W1_AW'(idx);
            end else begin
               state_nxt = S_L1_ACT;
            end
         end
         S_L1_ACT:  state_nxt = last_j ? S_L2_BIAS : S_L1_BIAS;
         S_L2_BIAS: begin
            b2_en     = 1'b1;
            b2_addr   = k;
            state_nxt = S_L2_MAC;
         end
         S_L2_MAC: begin
            load_bias = (idx == '0);
            acc_en    = (idx != '0);
            if (int'(idx) < N_HID) begin
               w2_en   = 1'b1;
               w2_addr = W2_AW'(k) * W2_AW'(N_HID) + W2_AW'(idx);
            end else begin
               state_nxt = S_L2_CMP;
            end
         end
         S_L2_CMP: state_nxt = last_k ? S_DONE : S_L2_BIAS;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx        <= '0;
         j          <= '0;
         k          <= '0;
         a_q        <= '0;
         best_score <= '0;
         best_idx   <= '0;
         predicted  <= '0;
         max_score  <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               idx <= '0;
               j   <= '0;
               k   <= '0;
            end
            S_L1_BIAS, S_L2_BIAS: idx <= '0;
            S_L1_MAC: begin
               if (int'(idx) < N_IN) a_q <= x_mem[idx[X_AW-1:0]];
               idx <= idx + CW'(1);
            end
            S_L1_ACT: if (!last_j) j <= j + H_AW'(1);
            S_L2_MAC: begin
               if (int'(idx) < N_HID) a_q <= h_mem[idx[H_AW-1:0]];
               idx <= idx + CW'(1);
            end
            S_L2_CMP: begin
               if (k == '0 || acc > best_score) begin
                  best_score <= acc;
                  best_idx   <= CLS_W'(k);
               end
               if (!last_k) k <= k + O_AW'(1);
            end
            S_DONE: begin
               predicted <= best_idx;
               max_score <= best_score;
               done      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Image and hidden activations are plain storage and survive reset.
   always_ff @(posedge clk) begin
      if (rst && state == S_IDLE && pix_we && int'(pix_addr) < N_IN)
         x_mem[pix_addr] <= pix_data;
      if (rst && state == S_L1_ACT)
         h_mem[j] <= relu_requant(acc, SHIFT);
   end

   nn_mac u_mac (
      .clk        (clk),
      .rst        (rst),
      .load_bias  (load_bias),
      .accumulate (acc_en),
      .bias       (mac_bias),
      .a          (a_q),
      .b          (mac_w),
      .acc        (acc)
   );

endmodule
